// File: rtl/addsub_share_ctrl_pkg.sv
// Shared encodings for the two-requester adder-subtractor controller.
package addsub_share_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/addsub_share_ctrl_core.sv
// Combinational ripple-carry adder-subtractor with carry and signed overflow.
module addsub16_core #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff = b ^ {WIDTH{sub}};

   // Subtract is a + ~b + 1, so the carry chain starts from sub.
   always_comb begin : ripple
      logic c;
      c    = sub;
      sum  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b_eff[i] ^ c;
         c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
      end
      cout = c;
   end

   assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin share of one adder-subtractor between two valid/ready requesters.
module addsub_share_ctrl
   import addsub_share_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_ovf
);

   state_t           state, state_nxt;
   logic             last_grant;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_sub, op_id;
   logic             grant, can_accept, accept;
   logic [WIDTH-1:0] core_sum;
   logic             core_cout, core_ovf;

   addsub16_core #(.WIDTH(WIDTH)) u_core (
      .a    (op_a),
      .b    (op_b),
      .sub  (op_sub),
      .sum  (core_sum),
      .cout (core_cout),
      .ovf  (core_ovf)
   );

   // Both pending: alternate away from the last winner; otherwise take whoever asks.
   always_comb begin
      grant = req_valid[1] ? ID_REQ1 : ID_REQ0;
      if (req_valid == 2'b11) grant = ~last_grant;
   end

   assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
   assign accept     = can_accept && (|req_valid) && !rst;
   assign req_ready  = accept ? ((grant == ID_REQ1) ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = accept ? ST_EXEC : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= ID_REQ1;
         op_a       <= '0;
         op_b       <= '0;
         op_sub     <= OP_ADD;
         op_id      <= ID_REQ0;
         rsp_valid  <= 1'b0;
         rsp_id     <= ID_REQ0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_ovf    <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= grant;
            op_id      <= grant;
            op_a       <= (grant == ID_REQ1) ? req1_a   : req0_a;
            op_b       <= (grant == ID_REQ1) ? req1_b   : req0_b;
            op_sub     <= (grant == ID_REQ1) ? req1_sub : req0_sub;
         end
         if (state == ST_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_sum   <= core_sum;
            rsp_cout  <= core_cout;
            rsp_ovf   <= core_ovf;
         end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/addsub_share_ctrl.md
Name: addsub_share_ctrl

Overview:
- Shares one combinational 16-bit adder-subtractor between two requesters.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants the core.
- The controller latches the granted operands, sequences one add/sub through the core, and returns a registered result tagged with the requester ID.
- Sits between the ALU front-end issue ports and the adder-subtractor datapath.

Parameters:
- WIDTH, 16, operand/result width; the design is only required to support 16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept, one-hot or zero, combinational
- req0_a, req0_b  in  WIDTH each  requester 0 operands
- req0_sub  in  1  requester 0 op: 0 = a+b, 1 = a-b
- req1_a, req1_b  in  WIDTH each  requester 1 operands
- req1_sub  in  1  requester 1 op
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_id  out  1  requester ID owning the result
- rsp_sum  out  WIDTH  a+b or a-b, modulo 2^WIDTH
- rsp_cout  out  1  carry out; on subtract, 1 = no borrow (a >= b unsigned)
- rsp_ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (requester 0 has first priority).
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - Operand regs cleared; req_ready=0 while rst is high.
- Operation regs: op_a, op_b, op_sub, op_id.
- Core:
  - b_eff = op_b XOR {WIDTH{op_sub}}; carry-in = op_sub.
  - sum/cout from the core.
  - ovf = (op_a[MSB] == b_eff[MSB]) AND (sum[MSB] != op_a[MSB]).
- Arbitration:
  - Round-robin over 2 requesters. If both valid, grant the one != last_grant; if one valid, grant it.
  - last_grant updates only on an accepted request.
  - req_ready[g]=1 only in the accept cycle of the granted requester; handshake = req_valid[g] & req_ready[g].
- FSM (one transaction in flight):
  - IDLE: if any req_valid, grant and latch operands + op_id, then go to EXEC; else stay.
  - EXEC: register core outputs into rsp_sum/rsp_cout/rsp_ovf, set rsp_id=op_id and rsp_valid<=1, then go to RESP. No accept in EXEC.
  - RESP: rsp_valid=1 and rsp_* held stable.
    - rsp_ready=0: stay; no accept.
    - rsp_ready=1 and a request is pending: accept (same grant rule), latch, rsp_valid<=0, go to EXEC.
    - rsp_ready=1 and no request: rsp_valid<=0, go to IDLE.
- Latency and throughput:
  - Accept at cycle t gives rsp_valid at t+2.
  - Sustained throughput with rsp_ready=1 is one result per 2 cycles.
- Requester rules (protocol; the controller does not check them):
  - Operands must stay stable while req_valid=1 until accepted.
  - req_valid must not drop before acceptance.
- Boundary conditions:
  - Both requests arrive in the same cycle as a response drain: the drain and the accept both occur that cycle.
  - A requester held off by backpressure keeps priority order; last_grant does not change without an accept.
  - Wrap-around: sum is modulo 2^WIDTH; cout and ovf are reported, never saturated.
  - Reset mid-transaction: the in-flight operation is discarded and no response is produced.
  - req_valid=2'b00 forever: stays in IDLE with outputs at reset values.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2)
  - op constant OP_ADD=1'b0, OP_SUB=1'b1
  - requester ID constants
- One natural sub-module: addsub16_core.
  - Purely combinational ripple adder-subtractor.
  - Inputs a, b, sub; outputs sum, cout, ovf.
- Arbiter, FSM and registers stay in addsub_share_ctrl.

Test Plan:
- Single add: requester 0 a=16'h0003, b=16'h0004, sub=0, rsp_ready=1 -> accepted cycle t; rsp_valid at t+2 with id=0, sum=16'h0007, cout=0, ovf=0.
- Subtract with borrow and signed overflow:
  - req1 a=16'h0002, b=16'h0005, sub=1 -> id=1, sum=16'hFFFD, cout=0, ovf=0.
  - req1 a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Round-robin: both requesters continuously valid from reset with rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; one result every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with req0 pending -> rsp_* held stable, req_ready=0; on rsp_ready=1, drain and accept the same cycle, next rsp_valid 2 cycles later.
- Wrap and reset: a=16'hFFFF, b=16'h0001 add -> sum=0, cout=1, ovf=0. Then assert rst during EXEC -> rsp_valid=0 immediately, and the next accept goes to requester 0.
